// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer:
// opcodes, FSM states and the registered decode flags.
package seq_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    OPERANDS,
    EXEC,
    MEM,
    WB,
    TRAP
  } seq_state_e;

  typedef struct packed {
    logic       rf_ra;
    logic       rf_rb;
    logic       alu;
    logic       pc_alu;
    logic       data;
    logic       we_data;
    logic [4:0] waddr;
  } dec_flags_t;

  // First applicable stage after `from`, in program order
  function automatic seq_state_e next_stage(
    dec_flags_t f,
    seq_state_e from
  );
    seq_state_e s;
    s = WB;
    if (from != MEM && f.data)
      s = MEM;
    if ((from == DECODE || from == OPERANDS) &&
        (f.alu || f.pc_alu))
      s = EXEC;
    if (from == DECODE && (f.rf_ra || f.rf_rb))
      s = OPERANDS;
    return s;
  endfunction

  function automatic logic wb_allowed(
    logic [6:0] opc,
    logic [4:0] wa
  );
    return (wa != 5'd0) &&
           (opc != OPC_BRANCH) &&
           (opc != OPC_STORE);
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Saturating wait-cycle counter; flags the cycle
// on which a wait state reaches its limit.
module ack_watchdog #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);
  localparam logic [W-1:0] MAX  = W'(ACK_TIMEOUT);

  logic [W-1:0] cnt;

  assign expired = count_en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (count_en && cnt != MAX)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Walks one instruction through decode, operand read,
// execute, memory and write-back with per-unit handshakes.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DECODE_CYCLES = 1,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_instr_i,
  output logic        fetch_ready_o,
  output logic        dec_req_o,
  output logic [31:0] dec_instr_o,
  input  logic        dec_req_rf_ra_i,
  input  logic        dec_req_rf_rb_i,
  input  logic        dec_req_alu_i,
  input  logic        dec_req_pc_alu_i,
  input  logic        dec_req_data_i,
  input  logic        dec_we_data_i,
  input  logic [4:0]  dec_rf_waddr_i,
  output logic        rf_req_o,
  input  logic        rf_ack_i,
  output logic        alu_req_o,
  input  logic        alu_ack_i,
  output logic        pc_alu_req_o,
  input  logic        pc_alu_ack_i,
  output logic        lsu_req_o,
  output logic        lsu_we_o,
  input  logic        lsu_ack_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic        busy_o,
  output logic        timeout_o
);

  seq_state_e state, nxt;
  dec_flags_t flags, din, fsel;
  logic [3:0] dec_cnt;
  logic dec_last;
  logic alu_done, pc_done;
  logic alu_hit, pc_hit, ex_done;
  logic rf_fire, lsu_fire;
  logic wd_clr, wd_en, wd_exp;
  logic wb_ok;

  assign din = '{
    rf_ra:   dec_req_rf_ra_i,
    rf_rb:   dec_req_rf_rb_i,
    alu:     dec_req_alu_i,
    pc_alu:  dec_req_pc_alu_i,
    data:    dec_req_data_i,
    we_data: dec_we_data_i,
    waddr:   dec_rf_waddr_i
  };

  // Outputs set on a DECODE exit must see the live flags
  assign fsel = (state == DECODE) ? din : flags;

  assign dec_last = dec_cnt == 4'(DECODE_CYCLES - 1);
  assign rf_fire  = rf_req_o & rf_ack_i;
  assign lsu_fire = lsu_req_o & lsu_ack_i;
  assign alu_hit  = alu_req_o & alu_ack_i;
  assign pc_hit   = pc_alu_req_o & pc_alu_ack_i;
  assign ex_done  =
    (!flags.alu | alu_done | alu_hit) &
    (!flags.pc_alu | pc_done | pc_hit);
  assign wb_ok = wb_allowed(dec_instr_o[6:0], fsel.waddr);

  assign wd_en =
    (state == OPERANDS && !rf_fire) ||
    (state == EXEC && !ex_done) ||
    (state == MEM && !lsu_fire);
  assign wd_clr = (nxt != state) &&
    (nxt == OPERANDS || nxt == EXEC || nxt == MEM);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (fetch_ready_o && fetch_valid_i)
          nxt = DECODE;
      DECODE:
        if (dec_last)
          nxt = next_stage(din, DECODE);
      OPERANDS:
        if (rf_fire)
          nxt = next_stage(flags, OPERANDS);
      EXEC:
        if (ex_done)
          nxt = next_stage(flags, EXEC);
      MEM:
        if (lsu_fire)
          nxt = WB;
      WB:
        nxt = IDLE;
      TRAP:
        nxt = TRAP;
      default:
        nxt = TRAP;
    endcase
    if (wd_exp)
      nxt = TRAP;
  end

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wd (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clear    (wd_clr),
    .count_en (wd_en),
    .expired  (wd_exp)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      flags         <= '0;
      dec_cnt       <= '0;
      alu_done      <= 1'b0;
      pc_done       <= 1'b0;
      fetch_ready_o <= 1'b0;
      busy_o        <= 1'b0;
      dec_req_o     <= 1'b0;
      dec_instr_o   <= '0;
      timeout_o     <= 1'b0;
      rf_req_o      <= 1'b0;
      alu_req_o     <= 1'b0;
      pc_alu_req_o  <= 1'b0;
      lsu_req_o     <= 1'b0;
      lsu_we_o      <= 1'b0;
      wb_en_o       <= 1'b0;
      wb_addr_o     <= '0;
    end else begin
      state         <= nxt;
      fetch_ready_o <= nxt == IDLE;
      busy_o        <= nxt != IDLE;
      dec_req_o     <= nxt == DECODE;
      timeout_o     <= nxt == TRAP;
      rf_req_o      <= nxt == OPERANDS;
      lsu_req_o     <= nxt == MEM;
      lsu_we_o      <= (nxt == MEM) & fsel.we_data;
      wb_en_o       <= (nxt == WB) & wb_ok;
      if (nxt == WB)
        wb_addr_o <= fsel.waddr;

      if (state == IDLE && nxt == DECODE) begin
        dec_instr_o <= fetch_instr_i;
        dec_cnt     <= '0;
      end else if (state == DECODE) begin
        dec_cnt <= dec_cnt + 4'd1;
      end
      if (state == DECODE && dec_last)
        flags <= din;

      if (nxt != EXEC) begin
        alu_req_o    <= 1'b0;
        pc_alu_req_o <= 1'b0;
        alu_done     <= 1'b0;
        pc_done      <= 1'b0;
      end else if (state != EXEC) begin
        alu_req_o    <= fsel.alu;
        pc_alu_req_o <= fsel.pc_alu;
        alu_done     <= 1'b0;
        pc_done      <= 1'b0;
      end else begin
        alu_req_o    <= alu_req_o & ~alu_ack_i;
        pc_alu_req_o <= pc_alu_req_o & ~pc_alu_ack_i;
        alu_done     <= alu_done | alu_hit;
        pc_done      <= pc_done | pc_hit;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a per-
// instruction expectation queue and unit responders.
module tb_instr_sequencer;

  localparam int D = 2;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_instr_i = '0;
  logic        fetch_ready_o;
  logic        dec_req_o;
  logic [31:0] dec_instr_o;
  logic        dec_req_rf_ra_i = 1'b0;
  logic        dec_req_rf_rb_i = 1'b0;
  logic        dec_req_alu_i = 1'b0;
  logic        dec_req_pc_alu_i = 1'b0;
  logic        dec_req_data_i = 1'b0;
  logic        dec_we_data_i = 1'b0;
  logic [4:0]  dec_rf_waddr_i = '0;
  logic        rf_req_o, alu_req_o, pc_alu_req_o;
  logic        lsu_req_o, lsu_we_o;
  logic        rf_ack_i = 1'b0;
  logic        alu_ack_i = 1'b0;
  logic        pc_alu_ack_i = 1'b0;
  logic        lsu_ack_i = 1'b0;
  logic        wb_en_o, busy_o, timeout_o;
  logic [4:0]  wb_addr_o;

  always #5 clk = ~clk;

  instr_sequencer #(
    .DECODE_CYCLES(D),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_instr_i    (fetch_instr_i),
    .fetch_ready_o    (fetch_ready_o),
    .dec_req_o        (dec_req_o),
    .dec_instr_o      (dec_instr_o),
    .dec_req_rf_ra_i  (dec_req_rf_ra_i),
    .dec_req_rf_rb_i  (dec_req_rf_rb_i),
    .dec_req_alu_i    (dec_req_alu_i),
    .dec_req_pc_alu_i (dec_req_pc_alu_i),
    .dec_req_data_i   (dec_req_data_i),
    .dec_we_data_i    (dec_we_data_i),
    .dec_rf_waddr_i   (dec_rf_waddr_i),
    .rf_req_o         (rf_req_o),
    .rf_ack_i         (rf_ack_i),
    .alu_req_o        (alu_req_o),
    .alu_ack_i        (alu_ack_i),
    .pc_alu_req_o     (pc_alu_req_o),
    .pc_alu_ack_i     (pc_alu_ack_i),
    .lsu_req_o        (lsu_req_o),
    .lsu_we_o         (lsu_we_o),
    .lsu_ack_i        (lsu_ack_i),
    .wb_en_o          (wb_en_o),
    .wb_addr_o        (wb_addr_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o)
  );

  typedef struct {
    int rf, alu, pc, lsu, lswe;
    int dec, wb, wba, lat, ord;
  } rec_t;

  rec_t exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [9:0] outs();
    return {fetch_ready_o, dec_req_o, rf_req_o,
            alu_req_o, pc_alu_req_o, lsu_req_o,
            lsu_we_o, wb_en_o, busy_o, timeout_o};
  endfunction

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, got, want);
    end
  endtask

  task automatic set_flags(
    input logic [5:0] fl,
    input logic [4:0] wa
  );
    {dec_req_rf_ra_i, dec_req_rf_rb_i,
     dec_req_alu_i, dec_req_pc_alu_i,
     dec_req_data_i, dec_we_data_i} = fl;
    dec_rf_waddr_i = wa;
  endtask

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (!fetch_ready_o && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, ".ready"}, 32'(fetch_ready_o), 1);
  endtask

  task automatic offer(input logic [31:0] ins);
    fetch_valid_i = 1'b1;
    fetch_instr_i = ins;
    @(negedge clk);
    fetch_valid_i = 1'b0;
    fetch_instr_i = 32'hDEADBEEF;
  endtask

  // fl = {ra, rb, alu, pc_alu, data, we}; dX = ack on
  // the X-th request-high cycle; spur acks idle units
  task automatic run(
    input string tag,
    input logic [31:0] ins,
    input logic [5:0] fl,
    input logic [4:0] wa,
    input int drf, input int dal,
    input int dpc, input int dls,
    input bit spur
  );
    rec_t e, o;
    int ex, g, idx;
    int f_rf, f_al, f_pc, f_ls, f_wb, f_ex;
    e.rf   = (fl[5] | fl[4]) ? drf : 0;
    e.alu  = fl[3] ? dal : 0;
    e.pc   = fl[2] ? dpc : 0;
    e.lsu  = fl[1] ? dls : 0;
    e.lswe = (fl[1] & fl[0]) ? dls : 0;
    e.dec  = D;
    e.wb   = (wa != 0 &&
              ins[6:0] != 7'b1100011 &&
              ins[6:0] != 7'b0100011) ? 1 : 0;
    e.wba  = e.wb != 0 ? int'(wa) : 0;
    ex     = e.alu > e.pc ? e.alu : e.pc;
    e.lat  = D + 2 + e.rf + ex + e.lsu;
    e.ord  = 1;
    exp_q.push_back(e);

    wait_ready(tag);
    set_flags(fl, wa);
    offer(ins);
    check({tag, ".instr"}, dec_instr_o, ins);

    o = '{default: 0};
    o.lat = 1;
    f_rf = 0; f_al = 0; f_pc = 0; f_ls = 0; f_wb = 0;
    g = 0;
    while (!fetch_ready_o && g < 200) begin
      g++;
      o.lat++;
      idx = o.lat;
      if (dec_req_o) o.dec++;
      if (rf_req_o) begin
        o.rf++;
        if (f_rf == 0) f_rf = idx;
      end
      if (alu_req_o) begin
        o.alu++;
        if (f_al == 0) f_al = idx;
      end
      if (pc_alu_req_o) begin
        o.pc++;
        if (f_pc == 0) f_pc = idx;
      end
      if (lsu_req_o) begin
        o.lsu++;
        if (f_ls == 0) f_ls = idx;
      end
      if (lsu_we_o) o.lswe++;
      if (wb_en_o) begin
        o.wb++;
        o.wba = int'(wb_addr_o);
        f_wb = idx;
      end
      rf_ack_i  = rf_req_o ? (o.rf == drf) : spur;
      alu_ack_i = alu_req_o ? (o.alu == dal) : spur;
      pc_alu_ack_i =
        pc_alu_req_o ? (o.pc == dpc) : spur;
      lsu_ack_i = lsu_req_o ? (o.lsu == dls) : spur;
      @(negedge clk);
    end
    rf_ack_i = 0; alu_ack_i = 0;
    pc_alu_ack_i = 0; lsu_ack_i = 0;

    o.ord = 1;
    f_ex = f_al != 0 ? f_al : f_pc;
    if (f_al != 0 && f_pc != 0 && f_al != f_pc)
      o.ord = 0;
    if (f_rf != 0 && f_ex != 0 && f_rf >= f_ex)
      o.ord = 0;
    if (f_ex != 0 && f_ls != 0 && f_ex >= f_ls)
      o.ord = 0;
    if (f_rf != 0 && f_ls != 0 && f_rf >= f_ls)
      o.ord = 0;
    if (f_wb != 0 && f_wb != o.lat)
      o.ord = 0;

    check({tag, ".retired"}, 32'(fetch_ready_o), 1);
    e = exp_q.pop_front();
    check({tag, ".rf"},   o.rf,   e.rf);
    check({tag, ".alu"},  o.alu,  e.alu);
    check({tag, ".pc"},   o.pc,   e.pc);
    check({tag, ".lsu"},  o.lsu,  e.lsu);
    check({tag, ".lswe"}, o.lswe, e.lswe);
    check({tag, ".dec"},  o.dec,  e.dec);
    check({tag, ".wb"},   o.wb,   e.wb);
    check({tag, ".wba"},  o.wba,  e.wba);
    check({tag, ".lat"},  o.lat,  e.lat);
    check({tag, ".ord"},  o.ord,  e.ord);
  endtask

  initial begin
    #200000;
    $display("FAIL global: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, g;
    #12;
    check("rst.outs", 32'(outs()), 0);
    check("rst.instr", dec_instr_o, 0);
    check("rst.wba", 32'(wb_addr_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.ready", 32'(fetch_ready_o), 1);
    check("idle.busy", 32'(busy_o), 0);

    run("jal", 32'h008000EF, 6'b000100, 5'd1,
        0, 0, 3, 0, 1'b0);
    run("beq", 32'h002082E3, 6'b110100, 5'd5,
        2, 0, 1, 0, 1'b0);
    run("store", 32'h0020A223, 6'b111011, 5'd4,
        1, 2, 0, 3, 1'b0);
    run("load", 32'h0000A003, 6'b101010, 5'd0,
        1, 1, 0, 2, 1'b0);
    run("both", 32'h002081B3, 6'b001100, 5'd3,
        0, 2, 5, 0, 1'b0);
    run("same", 32'h002081B3, 6'b001100, 5'd3,
        0, 4, 4, 0, 1'b0);
    run("empty", 32'hFFFFFFFF, 6'b000000, 5'd7,
        0, 0, 0, 0, 1'b0);
    run("spur", 32'h002084B3, 6'b000100, 5'd9,
        0, 0, 2, 0, 1'b1);

    // reset while EXEC waits on the ALU
    wait_ready("rstx");
    set_flags(6'b001000, 5'd3);
    offer(32'h002081B3);
    g = 0;
    while (!alu_req_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("rstx.alu_up", 32'(alu_req_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstx.outs", 32'(outs()), 0);
    check("rstx.instr", dec_instr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after", 32'h008000EF, 6'b000100, 5'd1,
        0, 0, 1, 0, 1'b0);

    // register file never acknowledges
    wait_ready("wd");
    set_flags(6'b100000, 5'd2);
    offer(32'h00008113);
    n = 0;
    g = 0;
    while (!timeout_o && g < 40) begin
      if (rf_req_o) n++;
      @(negedge clk);
      g++;
    end
    check("wd.rf_cycles", n, T);
    check("wd.outs", 32'(outs()), 10'b0000000011);
    repeat (3) @(negedge clk);
    check("wd.sticky", 32'(outs()), 10'b0000000011);
    #2;
    rst_n = 1'b0;
    #1;
    check("wd.rst_outs", 32'(outs()), 0);
    check("wd.rst_wba", 32'(wb_addr_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("wd.idle", 32'(outs()), 10'b1000000000);
    run("post", 32'h00000013, 6'b000000, 5'd0,
        0, 0, 0, 0, 1'b0);

    check("sb.empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
